// File: rtl/mem_access_unit.sv
// mem_access_unit: word RAM with byte-lane loads/stores, fault detection and busy handshake
// Ports: clk_i/reset_i (async, active high); rd_i/wr_i active-low requests; addr_i byte address;
//        wr_data_i store data (low lanes); funct3_i access size; rd_data_o formatted load data;
//        busy_o access in progress; fault_o one-cycle pulse on misaligned/illegal request.
module mem_access_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rd_i,
    input  logic                  wr_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [2:0]            funct3_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  busy_o,
    output logic                  fault_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    busy_q, fault_q;
    logic [31:0]             rd_data_q;
    logic [31:0]             hold_word_q;
    logic [1:0]              hold_lo_q;
    logic [2:0]              hold_f3_q;
    logic                    hold_rd_q;
    logic [31:0]             mem [0:2**ADDR_WIDTH-1];
    logic [ADDR_WIDTH-1:0]   idx;
    logic [31:0]             word;
    logic                    req, illegal, misaligned, fault_d, accept_d;
    logic [3:0]              be_d;
    logic [31:0]             wdata_d;
    logic                    unused_addr;

    // Upper address bits alias onto the RAM depth.
    assign unused_addr = ^addr_i[31:ADDR_WIDTH+2];
    assign idx  = addr_i[ADDR_WIDTH+1:2];
    assign word = mem[idx];

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] lo, input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        return f3[1:0] == 2'b00 ? {{24{b[7] & ~f3[2]}}, b} :
               f3[1:0] == 2'b01 ? {{16{h[15] & ~f3[2]}}, h} : w;
    endfunction

    always_comb begin
        req        = state_q == IDLE && (!rd_i || !wr_i);
        // 011/110/111 never legal; BU/HU have no store form.
        illegal    = funct3_i[1:0] == 2'b11 || (funct3_i[2] && (!wr_i || funct3_i[1]));
        misaligned = (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00) ||
                     (funct3_i[1:0] == 2'b01 && addr_i[0]);
        fault_d    = req && (illegal || misaligned);
        accept_d   = req && !fault_d;
        be_d       = funct3_i[1] ? 4'hF : funct3_i[0] ? (addr_i[1] ? 4'hC : 4'h3) : 4'b0001 << addr_i[1:0];
        wdata_d    = funct3_i[1] ? wr_data_i : funct3_i[0] ? {2{wr_data_i[15:0]}} : {4{wr_data_i[7:0]}};
    end

    // RAM and read holding register carry no reset; stores commit at the accepting edge.
    always_ff @(posedge clk_i) begin
        if (accept_d) begin
            hold_word_q <= word;
            hold_lo_q   <= addr_i[1:0];
            hold_f3_q   <= funct3_i;
            hold_rd_q   <= wr_i;
        end
        if (accept_d && !wr_i)
            for (int i = 0; i < 4; i++)
                if (be_d[i]) mem[idx][i*8 +: 8] <= wdata_d[i*8 +: 8];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
            rd_data_q <= 32'd0;
        end else begin
            fault_q <= fault_d;
            case (state_q)
                IDLE: if (accept_d) begin
                    if (WAIT_STATES > 0) begin
                        state_q <= WAIT;
                        busy_q  <= 1'b1;
                        cnt_q   <= 4'(WAIT_STATES - 1);
                    end else begin
                        // No wait states: data must be visible the cycle after acceptance.
                        state_q <= DONE;
                        if (wr_i) rd_data_q <= fmt(word, addr_i[1:0], funct3_i);
                    end
                end
                WAIT: if (cnt_q == 4'd0) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    if (hold_rd_q) rd_data_q <= fmt(hold_word_q, hold_lo_q, hold_f3_q);
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data_o = rd_data_q;
    assign busy_o    = busy_q;
    assign fault_o   = fault_q;
endmodule
